// File: rtl/dual_issue_scheduler_pkg.sv
// Shared types for the dual-issue scheduler: issue payload, pipe select,
// FSM states, scoreboard entries and a source-match helper.
package dual_issue_scheduler_pkg;

   localparam int unsigned REG_W = 7;   // register address width
   localparam int unsigned OP_W  = 11;  // opcode width
   localparam int unsigned LAT_W = 3;   // result latency width (1..7)

   // Target execution pipe
   typedef enum logic {
      EVEN = 1'b0,
      ODD  = 1'b1
   } pipe_t;

   // Decoded instruction as handed over by decode
   typedef struct packed {
      logic             vld;        // slot holds an instruction
      logic [OP_W-1:0]  opcode;     // opcode passed through to the pipes
      logic [REG_W-1:0] rt;         // destination register
      logic [REG_W-1:0] ra;         // source A
      logic [REG_W-1:0] rb;         // source B
      logic [REG_W-1:0] rc;         // source C
      logic [6:0]       I7;         // immediate fields
      logic [9:0]       I10;
      logic [15:0]      I16;
      logic [17:0]      I18;
      logic [LAT_W-1:0] lat;        // stage at which rt becomes forwardable
      pipe_t            pipe;       // even or odd pipe
      logic             uses_ra;    // source A is read
      logic             uses_rb;    // source B is read
      logic             uses_rc;    // source C is read
      logic             writes_rt;  // rt is written
   } issue_t;

   localparam issue_t NOP_ISSUE = issue_t'('0);

   // Buffer occupancy
   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      PAIR   = 2'd1,
      SECOND = 2'd2
   } state_t;

   // One in-flight destination in a pipe stage
   typedef struct packed {
      logic             vld;
      logic [REG_W-1:0] rt;
      logic [LAT_W-1:0] lat;
   } sb_entry_t;

   // True when the instruction reads register r through any used source
   function automatic logic reads_reg(input issue_t ins, input logic [REG_W-1:0] r);
      return (ins.uses_ra && (ins.ra == r)) ||
             (ins.uses_rb && (ins.rb == r)) ||
             (ins.uses_rc && (ins.rc == r));
   endfunction

endpackage

// File: rtl/dual_issue_scheduler_issue_scoreboard.sv
// In-flight destination tracker for both pipes.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   ev_push/ev_rt/ev_lat    : even-pipe issue of a register writer this edge
//   od_push/od_rt/od_lat    : odd-pipe issue of a register writer this edge
//   q0_src/q0_use           : three source registers and their use bits, query 0
//   q1_src/q1_use           : same for query 1
//   q0_blk/q1_blk           : query has a source that is not yet forwardable
module issue_scoreboard
   import dual_issue_scheduler_pkg::*;
#(
   parameter int unsigned STAGES = 7
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ev_push,
   input  logic [REG_W-1:0]      ev_rt,
   input  logic [LAT_W-1:0]      ev_lat,
   input  logic                  od_push,
   input  logic [REG_W-1:0]      od_rt,
   input  logic [LAT_W-1:0]      od_lat,
   input  logic [2:0][REG_W-1:0] q0_src,
   input  logic [2:0]            q0_use,
   input  logic [2:0][REG_W-1:0] q1_src,
   input  logic [2:0]            q1_use,
   output logic                  q0_blk,
   output logic                  q1_blk
);

   // Index s holds pipe stage s+1
   sb_entry_t ev_q [STAGES];
   sb_entry_t od_q [STAGES];

   // Entry at 1-based stage blocks src until the stage reaches its latency
   function automatic logic hit(input sb_entry_t e, input int unsigned stage,
                                input logic [REG_W-1:0] src);
      return e.vld && (e.rt == src) && (stage < 32'(e.lat));
   endfunction

   // Shift registers: new entries enter stage 1, oldest falls off after the last stage
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            ev_q[s] <= sb_entry_t'('0);
            od_q[s] <= sb_entry_t'('0);
         end
      end else begin
         ev_q[0] <= '{vld: ev_push, rt: ev_rt, lat: ev_lat};
         od_q[0] <= '{vld: od_push, rt: od_rt, lat: od_lat};
         for (int unsigned s = 1; s < STAGES; s++) begin
            ev_q[s] <= ev_q[s-1];
            od_q[s] <= od_q[s-1];
         end
      end
   end

   // RAW lookup for both queries against both pipes
   always_comb begin
      q0_blk = 1'b0;
      q1_blk = 1'b0;
      for (int unsigned s = 0; s < STAGES; s++) begin
         for (int unsigned k = 0; k < 3; k++) begin
            if (q0_use[k] && (hit(ev_q[s], s + 1, q0_src[k]) ||
                              hit(od_q[s], s + 1, q0_src[k])))
               q0_blk = 1'b1;
            if (q1_use[k] && (hit(ev_q[s], s + 1, q1_src[k]) ||
                              hit(od_q[s], s + 1, q1_src[k])))
               q1_blk = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue controller: buffers one decoded pair, issues each
// instruction to its pipe once its sources are forwardable, splits pairs on
// structural or intra-pair hazards, and drops buffered work on flush.
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   pair_valid/ready     : decode handshake, pair taken when both high
//   slot0_in, slot1_in   : older / younger instruction (slot1 vld=0 -> single)
//   flush                : branch-taken flush, discards buffered work
//   ep_out, ep_valid     : registered even-pipe issue
//   op_out, op_valid     : registered odd-pipe issue
//   stall_cnt            : saturating count of buffered-but-idle cycles
module dual_issue_scheduler
   import dual_issue_scheduler_pkg::*;
#(
   parameter int unsigned STAGES = 7,
   parameter int unsigned CNT_W  = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             pair_valid,
   output logic             pair_ready,
   input  issue_t           slot0_in,
   input  issue_t           slot1_in,
   input  logic             flush,
   output issue_t           ep_out,
   output logic             ep_valid,
   output issue_t           op_out,
   output logic             op_valid,
   output logic [CNT_W-1:0] stall_cnt
);

   state_t           state_q, state_d;
   issue_t           b0_q, b0_d;
   issue_t           b1_q, b1_d;
   issue_t           ep_q, ep_d;
   issue_t           op_q, op_d;
   logic             ep_vld_q, ep_vld_d;
   logic             op_vld_q, op_vld_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic             blk0, blk1;
   logic             pair_ok;
   logic             issue0, issue1;
   logic             all_issue;
   logic             accept;

   // RAW lookup: query 0 is B0, query 1 is B1; pushes follow the routed issue
   issue_scoreboard #(
      .STAGES (STAGES)
   ) u_sb (
      .clock   (clock),
      .reset   (reset),
      .ev_push (ep_vld_d && ep_d.writes_rt),
      .ev_rt   (ep_d.rt),
      .ev_lat  (ep_d.lat),
      .od_push (op_vld_d && op_d.writes_rt),
      .od_rt   (op_d.rt),
      .od_lat  (op_d.lat),
      .q0_src  ({b0_q.rc, b0_q.rb, b0_q.ra}),
      .q0_use  ({b0_q.uses_rc, b0_q.uses_rb, b0_q.uses_ra}),
      .q1_src  ({b1_q.rc, b1_q.rb, b1_q.ra}),
      .q1_use  ({b1_q.uses_rc, b1_q.uses_rb, b1_q.uses_ra}),
      .q0_blk  (blk0),
      .q1_blk  (blk1)
   );

   // State register and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= EMPTY;
         b0_q     <= NOP_ISSUE;
         b1_q     <= NOP_ISSUE;
         ep_q     <= NOP_ISSUE;
         op_q     <= NOP_ISSUE;
         ep_vld_q <= 1'b0;
         op_vld_q <= 1'b0;
         stall_q  <= '0;
      end else begin
         state_q  <= state_d;
         b0_q     <= b0_d;
         b1_q     <= b1_d;
         ep_q     <= ep_d;
         op_q     <= op_d;
         ep_vld_q <= ep_vld_d;
         op_vld_q <= op_vld_d;
         stall_q  <= stall_d;
      end
   end

   // Issue decision, handshake, routing and stall counting
   always_comb begin
      issue0    = 1'b0;
      issue1    = 1'b0;
      all_issue = 1'b0;
      ep_d      = NOP_ISSUE;
      op_d      = NOP_ISSUE;
      ep_vld_d  = 1'b0;
      op_vld_d  = 1'b0;
      stall_d   = stall_q;

      // B1 may join B0 only on the other pipe with no RAW/WAW against B0
      pair_ok = (b1_q.pipe != b0_q.pipe) &&
                !(b0_q.writes_rt && reads_reg(b1_q, b0_q.rt)) &&
                !(b0_q.writes_rt && b1_q.writes_rt && (b1_q.rt == b0_q.rt));

      if (!reset && !flush) begin
         case (state_q)
            PAIR: begin
               issue0    = !blk0;
               issue1    = !blk0 && pair_ok && !blk1;
               all_issue = issue0 && issue1;
            end
            SECOND: begin
               issue1    = !blk1;
               all_issue = issue1;
            end
            default: ;
         endcase
      end

      pair_ready = !reset && !flush && ((state_q == EMPTY) || all_issue);
      accept     = pair_valid && pair_ready;

      if (issue0) begin
         if (b0_q.pipe == EVEN) begin
            ep_d     = b0_q;
            ep_vld_d = 1'b1;
         end else begin
            op_d     = b0_q;
            op_vld_d = 1'b1;
         end
      end
      if (issue1) begin
         if (b1_q.pipe == EVEN) begin
            ep_d     = b1_q;
            ep_vld_d = 1'b1;
         end else begin
            op_d     = b1_q;
            op_vld_d = 1'b1;
         end
      end

      if ((state_q != EMPTY) && !issue0 && !issue1 && !flush && (stall_q != '1))
         stall_d = stall_q + CNT_W'(1);
   end

   // Next state and buffer contents
   always_comb begin
      state_d = state_q;
      b0_d    = b0_q;
      b1_d    = b1_q;

      if (flush) begin
         state_d = EMPTY;
         b0_d    = NOP_ISSUE;
         b1_d    = NOP_ISSUE;
      end else begin
         case (state_q)
            PAIR: begin
               if (issue0 && issue1) state_d = EMPTY;
               else if (issue0)      state_d = SECOND;
            end
            SECOND: begin
               if (issue1) state_d = EMPTY;
            end
            default: ;
         endcase

         // Accept only happens when the buffer is empty or fully drains now
         if (accept) begin
            if (slot1_in.vld) begin
               state_d = PAIR;
               b0_d    = slot0_in;
               b1_d    = slot1_in;
            end else begin
               state_d = SECOND;
               b0_d    = NOP_ISSUE;
               b1_d    = slot0_in;
            end
         end
      end
   end

   assign ep_out    = ep_q;
   assign op_out    = op_q;
   assign ep_valid  = ep_vld_q;
   assign op_valid  = op_vld_q;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler with hand-computed expectations.
module tb_dual_issue_scheduler;
   import dual_issue_scheduler_pkg::*;

   localparam int unsigned CNT_W = 32;

   logic             clock;
   logic             reset;
   logic             pair_valid;
   logic             pair_ready;
   issue_t           slot0_in;
   issue_t           slot1_in;
   logic             flush;
   issue_t           ep_out;
   logic             ep_valid;
   issue_t           op_out;
   logic             op_valid;
   logic [CNT_W-1:0] stall_cnt;

   int checks;
   int errors;

   dual_issue_scheduler #(
      .STAGES (7),
      .CNT_W  (CNT_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .pair_valid (pair_valid),
      .pair_ready (pair_ready),
      .slot0_in   (slot0_in),
      .slot1_in   (slot1_in),
      .flush      (flush),
      .ep_out     (ep_out),
      .ep_valid   (ep_valid),
      .op_out     (op_out),
      .op_valid   (op_valid),
      .stall_cnt  (stall_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic issue_t mk(input pipe_t p, input int rt, input int ra, input int rb,
                                 input bit wr, input bit ua, input bit ub, input int lat);
      issue_t i;
      i           = NOP_ISSUE;
      i.vld       = 1'b1;
      i.opcode    = 11'(rt * 3 + ra);
      i.pipe      = p;
      i.rt        = 7'(rt);
      i.ra        = 7'(ra);
      i.rb        = 7'(rb);
      i.writes_rt = wr;
      i.uses_ra   = ua;
      i.uses_rb   = ub;
      i.lat       = 3'(lat);
      return i;
   endfunction

   task automatic drain();
      for (int i = 0; i < 9; i++) tick();
   endtask

   issue_t a0, a1, b0, b1;

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      flush      = 1'b0;
      pair_valid = 1'b0;
      slot0_in   = NOP_ISSUE;
      slot1_in   = NOP_ISSUE;

      // Reset values
      tick();
      tick();
      check_eq("rst_ep_valid", 128'(ep_valid), 128'(1'b0));
      check_eq("rst_op_valid", 128'(op_valid), 128'(1'b0));
      check_eq("rst_ep_out", 128'(ep_out), 128'(NOP_ISSUE));
      check_eq("rst_op_out", 128'(op_out), 128'(NOP_ISSUE));
      check_eq("rst_stall", 128'(stall_cnt), 128'(0));
      check_eq("rst_ready", 128'(pair_ready), 128'(1'b0));
      reset = 1'b0;
      #1;
      check_eq("idle_ready", 128'(pair_ready), 128'(1'b1));

      // Independent pair: both issue the edge after accept
      a0 = mk(EVEN, 3, 1, 2, 1, 1, 1, 2);
      a1 = mk(ODD, 4, 5, 0, 1, 1, 0, 6);
      slot0_in = a0; slot1_in = a1; pair_valid = 1'b1;
      tick();
      pair_valid = 1'b0;
      check_eq("ind_accept_ep_valid", 128'(ep_valid), 128'(1'b0));
      tick();
      check_eq("ind_ep_valid", 128'(ep_valid), 128'(1'b1));
      check_eq("ind_op_valid", 128'(op_valid), 128'(1'b1));
      check_eq("ind_ep_out", 128'(ep_out), 128'(a0));
      check_eq("ind_op_out", 128'(op_out), 128'(a1));
      check_eq("ind_empty_ready", 128'(pair_ready), 128'(1'b1));
      tick();
      check_eq("ind_after_ep_valid", 128'(ep_valid), 128'(1'b0));
      drain();

      // Structural split: two EVEN instructions issue on consecutive edges
      a0 = mk(EVEN, 20, 21, 0, 1, 1, 0, 2);
      a1 = mk(EVEN, 22, 23, 0, 1, 1, 0, 2);
      slot0_in = a0; slot1_in = a1; pair_valid = 1'b1;
      tick();
      pair_valid = 1'b0;
      tick();
      check_eq("split_e1_ep_out", 128'(ep_out), 128'(a0));
      check_eq("split_e1_ep_valid", 128'(ep_valid), 128'(1'b1));
      check_eq("split_e1_op_valid", 128'(op_valid), 128'(1'b0));
      tick();
      check_eq("split_e2_ep_out", 128'(ep_out), 128'(a1));
      check_eq("split_e2_ep_valid", 128'(ep_valid), 128'(1'b1));
      check_eq("split_stall", 128'(stall_cnt), 128'(0));
      drain();

      // RAW latency: lat-6 producer, consumer streams in behind it
      a0 = mk(EVEN, 10, 1, 0, 1, 1, 0, 6);
      a1 = NOP_ISSUE;
      b0 = mk(EVEN, 11, 10, 0, 1, 1, 0, 1);
      b1 = mk(ODD, 12, 13, 0, 1, 1, 0, 1);
      slot0_in = a0; slot1_in = a1; pair_valid = 1'b1;
      tick();
      slot0_in = b0; slot1_in = b1;
      tick();
      pair_valid = 1'b0;
      check_eq("raw_prod_ep_out", 128'(ep_out), 128'(a0));
      check_eq("raw_prod_op_valid", 128'(op_valid), 128'(1'b0));
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("raw_hold_ep_valid", 128'(ep_valid), 128'(1'b0));
         check_eq("raw_hold_op_valid", 128'(op_valid), 128'(1'b0));
      end
      tick();
      check_eq("raw_cons_ep_out", 128'(ep_out), 128'(b0));
      check_eq("raw_cons_op_out", 128'(op_out), 128'(b1));
      check_eq("raw_cons_ep_valid", 128'(ep_valid), 128'(1'b1));
      check_eq("raw_cons_op_valid", 128'(op_valid), 128'(1'b1));
      check_eq("raw_stall", 128'(stall_cnt), 128'(5));
      drain();

      // Intra-pair dependence, lat=1: B1 one edge after B0
      a0 = mk(EVEN, 7, 1, 0, 1, 1, 0, 1);
      a1 = mk(ODD, 8, 7, 0, 1, 1, 0, 1);
      slot0_in = a0; slot1_in = a1; pair_valid = 1'b1;
      tick();
      pair_valid = 1'b0;
      tick();
      check_eq("dep1_e1_ep_out", 128'(ep_out), 128'(a0));
      check_eq("dep1_e1_op_valid", 128'(op_valid), 128'(1'b0));
      tick();
      check_eq("dep1_e2_op_out", 128'(op_out), 128'(a1));
      check_eq("dep1_e2_op_valid", 128'(op_valid), 128'(1'b1));
      check_eq("dep1_e2_ep_valid", 128'(ep_valid), 128'(1'b0));
      drain();

      // Intra-pair dependence, lat=3: B1 waits for stage 3
      a0 = mk(EVEN, 7, 2, 0, 1, 1, 0, 3);
      a1 = mk(ODD, 9, 7, 0, 1, 1, 0, 1);
      slot0_in = a0; slot1_in = a1; pair_valid = 1'b1;
      tick();
      pair_valid = 1'b0;
      tick();
      check_eq("dep3_e1_ep_out", 128'(ep_out), 128'(a0));
      tick();
      check_eq("dep3_e2_op_valid", 128'(op_valid), 128'(1'b0));
      tick();
      check_eq("dep3_e3_op_valid", 128'(op_valid), 128'(1'b0));
      tick();
      check_eq("dep3_e4_op_out", 128'(op_out), 128'(a1));
      check_eq("dep3_e4_op_valid", 128'(op_valid), 128'(1'b1));
      check_eq("dep3_stall", 128'(stall_cnt), 128'(7));
      drain();

      // Flush while PAIR is blocked
      a0 = mk(EVEN, 30, 1, 0, 1, 1, 0, 7);
      b0 = mk(EVEN, 31, 30, 0, 1, 1, 0, 1);
      b1 = mk(ODD, 32, 33, 0, 1, 1, 0, 1);
      slot0_in = a0; slot1_in = NOP_ISSUE; pair_valid = 1'b1;
      tick();
      slot0_in = b0; slot1_in = b1;
      tick();
      pair_valid = 1'b0;
      tick();
      check_eq("fl_blocked_ep_valid", 128'(ep_valid), 128'(1'b0));
      flush = 1'b1;
      #1;
      check_eq("fl_ready_low", 128'(pair_ready), 128'(1'b0));
      tick();
      flush = 1'b0;
      check_eq("fl_ep_valid", 128'(ep_valid), 128'(1'b0));
      check_eq("fl_op_valid", 128'(op_valid), 128'(1'b0));
      check_eq("fl_stall", 128'(stall_cnt), 128'(8));
      a0 = mk(EVEN, 40, 41, 0, 1, 1, 0, 1);
      a1 = mk(ODD, 42, 43, 0, 1, 1, 0, 1);
      slot0_in = a0; slot1_in = a1; pair_valid = 1'b1;
      #1;
      check_eq("fl_next_ready", 128'(pair_ready), 128'(1'b1));
      tick();
      pair_valid = 1'b0;
      tick();
      check_eq("fl_next_ep_out", 128'(ep_out), 128'(a0));
      check_eq("fl_next_op_out", 128'(op_out), 128'(a1));
      tick();
      check_eq("fl_no_stale_ep", 128'(ep_valid), 128'(1'b0));
      drain();

      // Reset in SECOND with a blocking in-flight producer
      a0 = mk(EVEN, 50, 1, 0, 1, 1, 0, 7);
      b0 = mk(EVEN, 51, 50, 0, 1, 1, 0, 1);
      slot0_in = a0; slot1_in = NOP_ISSUE; pair_valid = 1'b1;
      tick();
      slot0_in = b0;
      tick();
      pair_valid = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      check_eq("rs_ready_low", 128'(pair_ready), 128'(1'b0));
      tick();
      reset = 1'b0;
      check_eq("rs_ep_valid", 128'(ep_valid), 128'(1'b0));
      check_eq("rs_op_valid", 128'(op_valid), 128'(1'b0));
      check_eq("rs_ep_out", 128'(ep_out), 128'(NOP_ISSUE));
      check_eq("rs_op_out", 128'(op_out), 128'(NOP_ISSUE));
      check_eq("rs_stall", 128'(stall_cnt), 128'(0));
      b1 = mk(EVEN, 52, 50, 0, 1, 1, 0, 1);
      slot0_in = b1; pair_valid = 1'b1;
      tick();
      pair_valid = 1'b0;
      tick();
      check_eq("rs_cons_ep_valid", 128'(ep_valid), 128'(1'b1));
      check_eq("rs_cons_ep_out", 128'(ep_out), 128'(b1));
      check_eq("rs_cons_stall", 128'(stall_cnt), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
